// File: rtl/reg15_input_conditioner_if.sv
// reg15_input_conditioner_if: groups the conditioner's input controls and conditioned outputs.
//   raw_in       unsynchronized external input (button/switch)
//   clear_count  synchronous clear of press_count, active-high
//   reg15_input  debounced level feeding regfile reg15_input
//   rise_pulse   one-cycle pulse on accepted 0->1
//   fall_pulse   one-cycle pulse on accepted 1->0
//   press_count  saturating count of accepted rising edges
//   busy         high while a new level is being qualified
interface reg15_input_conditioner_if #(
  parameter int PRESS_W = 16
);
  logic               raw_in;
  logic               clear_count;
  logic               reg15_input;
  logic               rise_pulse;
  logic               fall_pulse;
  logic [PRESS_W-1:0] press_count;
  logic               busy;
  modport master (
    output raw_in, clear_count,
    input  reg15_input, rise_pulse, fall_pulse, press_count, busy
  );
  modport slave (
    input  raw_in, clear_count,
    output reg15_input, rise_pulse, fall_pulse, press_count, busy
  );
endinterface

// File: rtl/reg15_input_conditioner.sv
// reg15_input_conditioner: synchronizes, debounces and edge-detects one raw input for r15.
//   clock    system clock, all state on posedge
//   reset_n  asynchronous active-low reset
//   bus      slave side of reg15_input_conditioner_if (raw_in/clear_count in, conditioned outputs out)
module reg15_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int PRESS_W         = 16
) (
  input logic                     clock,
  input logic                     reset_n,
  reg15_input_conditioner_if.slave bus
);
  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRESS_W-1:0] PRESS_MAX = '1;
  logic               s1, s2;
  logic [1:0]         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               level, rise_q, fall_q;
  logic [PRESS_W-1:0] press, press_cleared, press_d;
  logic               rise, fall;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE_LOW:  if (s2) begin state_d = WAIT_HIGH; cnt_d = CNT_W'(1); end
      WAIT_HIGH: if (!s2) begin state_d = IDLE_LOW; cnt_d = '0; end
                 else if (cnt == LAST) begin state_d = IDLE_HIGH; cnt_d = '0; end
                 else cnt_d = cnt + CNT_W'(1);
      IDLE_HIGH: if (!s2) begin state_d = WAIT_LOW; cnt_d = CNT_W'(1); end
      WAIT_LOW:  if (s2) begin state_d = IDLE_HIGH; cnt_d = '0; end
                 else if (cnt == LAST) begin state_d = IDLE_LOW; cnt_d = '0; end
                 else cnt_d = cnt + CNT_W'(1);
      default:   begin state_d = IDLE_LOW; cnt_d = '0; end
    endcase
  end
  assign rise = state == WAIT_HIGH && state_d == IDLE_HIGH;
  assign fall = state == WAIT_LOW && state_d == IDLE_LOW;
  // Clear takes priority, then a coincident accepted rise counts from zero.
  assign press_cleared = bus.clear_count ? '0 : press;
  assign press_d = rise && press_cleared != PRESS_MAX ? press_cleared + PRESS_W'(1) : press_cleared;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= IDLE_LOW;
      cnt    <= '0;
      level  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      press  <= '0;
    end else begin
      s1     <= bus.raw_in;
      s2     <= s1;
      state  <= state_d;
      cnt    <= cnt_d;
      level  <= state_d == IDLE_HIGH || state_d == WAIT_LOW;
      rise_q <= rise;
      fall_q <= fall;
      press  <= press_d;
    end
  end
  assign bus.reg15_input = level;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.press_count = press;
  assign bus.busy        = state == WAIT_HIGH || state == WAIT_LOW;
endmodule

// File: tb/tb_reg15_input_conditioner.sv
// tb_reg15_input_conditioner: randomized and directed checks against a run-length debounce model.
module tb_reg15_input_conditioner;
  localparam int D = 4;
  localparam int PW = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  reg15_input_conditioner_if #(.PRESS_W(PW)) bus ();
  reg15_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8), .PRESS_W(PW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clock = ~clock;
  logic          m_s1, m_s2, m_lvl, m_rise, m_fall;
  int            m_run;
  logic [PW-1:0] m_cnt;
  function automatic logic [7:0] obs();
    return {bus.reg15_input, bus.rise_pulse, bus.fall_pulse, bus.busy, bus.press_count};
  endfunction
  function automatic logic [7:0] expv();
    return {m_lvl, m_rise, m_fall, m_run != 0, m_cnt};
  endfunction
  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_run = 0; m_cnt = 0;
  endtask
  // A new level is accepted after D consecutive synchronized samples disagreeing with it.
  task automatic step(input logic r, input logic c);
    logic acc;
    bus.raw_in = r;
    bus.clear_count = c;
    @(posedge clock);
    acc = 0;
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == D) begin m_lvl = m_s2; m_run = 0; acc = 1; end
    end else m_run = 0;
    m_rise = acc && m_lvl;
    m_fall = acc && !m_lvl;
    if (c) m_cnt = 0;
    if (m_rise && m_cnt != {PW{1'b1}}) m_cnt++;
    m_s2 = m_s1;
    m_s1 = r;
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      bus.raw_in = i[0];
      @(posedge clock); #1;
      checks++;
      if (obs() !== 8'h00) begin errors++; $display("FAIL reset_hold got %h want 00", obs()); end
    end
    bus.raw_in = 0;
    #2 reset_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      checks++;
      if (obs() !== 8'h00) begin errors++; $display("FAIL reset_release got %h want 00", obs()); end
    end
  endtask
  task automatic test_rise();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL rise_model edge %0d got %h want %h", i, obs(), expv()); end
      checks++;
      if (i == 5 && bus.reg15_input !== 1'b0) begin errors++; $display("FAIL rise_early got %b want 0", bus.reg15_input); end
      if (i == 6 && {bus.reg15_input, bus.rise_pulse, bus.press_count} !== {2'b11, 4'd1}) begin
        errors++; $display("FAIL rise_edge6 got %b%b%0d want 1 1 1", bus.reg15_input, bus.rise_pulse, bus.press_count);
      end
      if (i == 7 && {bus.rise_pulse, bus.press_count} !== {1'b0, 4'd1}) begin
        errors++; $display("FAIL rise_one_cycle got %b %0d want 0 1", bus.rise_pulse, bus.press_count);
      end
    end
  endtask
  task automatic test_glitch();
    logic [PW-1:0] c0;
    for (int i = 0; i < 10; i++) step(0, 0);
    c0 = bus.press_count;
    for (int i = 0; i < 14; i++) begin
      step(i < 3, 0);
      checks++;
      if ({bus.reg15_input, bus.rise_pulse, bus.fall_pulse, bus.press_count} !== {3'b000, c0} || obs() !== expv()) begin
        errors++; $display("FAIL glitch cyc %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask
  task automatic test_saturate();
    int n;
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 8; i++) step(1, 0);
      for (int i = 0; i < 8; i++) step(0, 0);
    end
    checks++;
    if (bus.press_count !== 4'd15 || obs() !== expv()) begin
      errors++; $display("FAIL saturate got %0d want 15", bus.press_count);
    end
    n = 0;
    while (!(m_lvl == 0 && m_run == D - 1 && m_s2 == 1) && n < 20) begin step(1, 0); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL sat_timeout got %0d want <20", n); end
    step(1, 1);
    checks++;
    if ({bus.rise_pulse, bus.press_count} !== {1'b1, 4'd1} || obs() !== expv()) begin
      errors++; $display("FAIL clear_rise got %b %0d want 1 1", bus.rise_pulse, bus.press_count);
    end
  endtask
  task automatic test_fall_reset();
    int n;
    for (int i = 0; i < 6; i++) step(1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL fall_model edge %0d got %h want %h", i, obs(), expv()); end
      checks++;
      if (i == 5 && bus.reg15_input !== 1'b1) begin errors++; $display("FAIL fall_early got %b want 1", bus.reg15_input); end
      if (i == 6 && {bus.reg15_input, bus.fall_pulse} !== 2'b01) begin
        errors++; $display("FAIL fall_edge6 got %b%b want 01", bus.reg15_input, bus.fall_pulse);
      end
    end
    for (int i = 0; i < 8; i++) step(1, 0);
    n = 0;
    while (!(m_lvl == 1 && m_run == 2) && n < 20) begin step(0, 0); n++; end
    checks++;
    if (n >= 20 || bus.busy !== 1'b1) begin errors++; $display("FAIL wait_low_reach got busy %b want 1", bus.busy); end
    #2 reset_n = 0;
    #1;
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL async_reset got %h want 00", obs()); end
    model_reset();
    reset_n = 1;
    for (int i = 1; i <= 7; i++) begin
      step(1, 0);
      checks++;
      if (obs() !== expv() || (i <= 5 && bus.reg15_input !== 1'b0) || (i == 6 && bus.reg15_input !== 1'b1)) begin
        errors++; $display("FAIL post_reset edge %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask
  task automatic test_toggle();
    logic l0;
    l0 = bus.reg15_input;
    for (int i = 0; i < 24; i++) begin
      step(i[0], 0);
      checks++;
      if (bus.reg15_input !== l0 || obs() !== expv()) begin
        errors++; $display("FAIL toggle cyc %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask
  task automatic test_random();
    logic r;
    int hold;
    r = 0;
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin r = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 7); end
      hold--;
      step(r, $urandom_range(0, 19) == 0);
      checks++;
      if (obs() !== expv() || (bus.rise_pulse && bus.fall_pulse)) begin
        errors++; $display("FAIL random cyc %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask
  initial begin
    bus.raw_in = 0;
    bus.clear_count = 0;
    model_reset();
    test_reset();
    test_rise();
    test_glitch();
    test_saturate();
    test_fall_reset();
    test_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
